// File: rtl/regfile_read_arbiter.sv
// Round-robin read arbiter in front of a 32-entry register-file multiplexer.
// Four requesters compete for one read port. Each transaction takes an
// IDLE -> READ -> RESP trip of at least three cycles. Register x0 always
// reads as zero.
module regfile_read_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    input  logic [5*NUM_REQ-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic [4:0]           mux_sel_out,
    input  logic [XLEN-1:0]      mux_data_in,
    output logic [NUM_REQ-1:0]   rsp_valid_out,
    output logic [XLEN-1:0]      rsp_data_out,
    input  logic [NUM_REQ-1:0]   rsp_ready_in,
    input  logic                 flush_in,
    output logic                 busy_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [1:0]      id;
    logic [4:0]      addr;
    logic [XLEN-1:0] rsp_data;

    logic            any_valid;
    logic [1:0]      win;
    logic [4:0]      win_addr;

    // Pick the first valid requester at or above rr_ptr, wrapping 3 -> 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        win       = rr_ptr;
        any_valid = |req_valid_in;
        // Scan from the farthest offset down so the nearest valid one is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_in[rr_ptr + k[1:0]]) begin
                win = rr_ptr + k[1:0];
            end
        end
    end

    // Extract the winner's 5-bit register index from the packed address bus.
    always_comb begin
        win_addr = 5'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == i[1:0]) begin
                win_addr = req_addr_in[5*i +: 5];
            end
        end
    end

    // Grant is one-hot at the winner, only in IDLE, and never while flushing or in reset.
    always_comb begin
        req_ready_out = '0;
        if (state == IDLE && any_valid && !flush_in && !reset_in) begin
            req_ready_out = NUM_REQ'(1) << win;
        end
    end

    // Outputs are decoded purely from registered state, so reset clears them immediately.
    assign mux_sel_out   = (state == READ) ? addr : 5'd0;
    assign rsp_valid_out = (state == RESP) ? (NUM_REQ'(1) << id) : '0;
    assign rsp_data_out  = rsp_data;
    assign busy_out      = (state != IDLE);

    // Transaction FSM: accept, read the mux, hold the response until taken or flushed.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            id       <= 2'd0;
            addr     <= 5'd0;
            rsp_data <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (any_valid && !flush_in) begin
                        id    <= win;
                        addr  <= win_addr;
                        state <= READ;
                    end
                end
                READ: begin
                    if (flush_in) begin
                        state  <= IDLE;
                        rr_ptr <= id + 2'd1;
                    end else begin
                        // x0 is hardwired to zero whatever the mux drives.
                        rsp_data <= (addr == 5'd0) ? '0 : mux_data_in;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    // Flush wins over a simultaneous response acceptance.
                    if (flush_in || rsp_ready_in[id]) begin
                        state  <= IDLE;
                        rr_ptr <= id + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: reset, single read, x0, round-robin,
// backpressure, flush and mid-transaction reset, each with hand-computed results.
module tb_regfile_read_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [19:0]     req_addr;
    logic [3:0]      req_ready;
    logic [4:0]      mux_sel;
    logic [XLEN-1:0] mux_data;
    logic [3:0]      rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic [3:0]      rsp_ready;
    logic            flush;
    logic            busy;

    logic [XLEN-1:0] regs [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register-file multiplexer model.
    assign mux_data = regs[mux_sel];

    regfile_read_arbiter #(.XLEN(XLEN), .NUM_REQ(4)) dut (
        .clock_in      (clk),
        .reset_in      (rst),
        .req_valid_in  (req_valid),
        .req_addr_in   (req_addr),
        .req_ready_out (req_ready),
        .mux_sel_out   (mux_sel),
        .mux_data_in   (mux_data),
        .rsp_valid_out (rsp_valid),
        .rsp_data_out  (rsp_data),
        .rsp_ready_in  (rsp_ready),
        .flush_in      (flush),
        .busy_out      (busy)
    );

    function automatic logic [19:0] pack(input logic [4:0] a3, input logic [4:0] a2,
                                         input logic [4:0] a1, input logic [4:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (mux_sel !== 5'd0) begin errors++; $display("FAIL reset_mux_sel: got %0d want 0", mux_sel); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick;
        rst = 1'b0;
        #1;
    endtask

    // Requester 1 reads x7; rr_ptr ends at 2.
    task automatic test_single;
        req_addr  = pack(5'd0, 5'd0, 5'd7, 5'd0);
        req_valid = 4'b0010;
        rsp_ready = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        tick;
        // Changing the requester after acceptance must not disturb the read.
        req_addr  = pack(5'd0, 5'd0, 5'd9, 5'd0);
        req_valid = 4'b0000;
        #1;
        checks++; if (mux_sel !== 5'd7) begin errors++; $display("FAIL single_mux_sel: got %0d want 7", mux_sel); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_read_busy: got %b want 1", busy); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_read_rsp_valid: got %b want 0000", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp_data: got %h want deadbeef", rsp_data); end
        checks++; if (mux_sel !== 5'd0) begin errors++; $display("FAIL single_resp_mux_sel: got %0d want 0", mux_sel); end
        rsp_ready = 4'b0010;
        tick;
        rsp_ready = 4'b0000;
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_done_valid: got %b want 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b want 0", busy); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold_data: got %h want deadbeef", rsp_data); end
    endtask

    // Requester 2 reads x0 while the mux drives all ones; rr_ptr ends at 3.
    task automatic test_x0;
        req_addr  = pack(5'd0, 5'd0, 5'd0, 5'd0);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL x0_grant: got %b want 0100", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL x0_rsp_valid: got %b want 0100", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL x0_rsp_data: got %h want 0", rsp_data); end
        rsp_ready = 4'b0100;
        tick;
        rsp_ready = 4'b0000;
    endtask

    // From reset, all four valid and always ready: grants 0,1,2,3,0 every 3 cycles.
    task automatic test_round_robin;
        logic [3:0] exp_grant;
        logic [4:0] exp_addr;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_addr  = pack(5'd7, 5'd6, 5'd5, 5'd4);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_grant = 4'b0001 << (g % 4);
            exp_addr  = 5'(4 + (g % 4));
            checks++; if (req_ready !== exp_grant) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_grant); end
            tick;
            checks++; if (mux_sel !== exp_addr) begin errors++; $display("FAIL rr_mux_sel%0d: got %0d want %0d", g, mux_sel, exp_addr); end
            tick;
            checks++; if (rsp_valid !== exp_grant) begin errors++; $display("FAIL rr_rsp_valid%0d: got %b want %b", g, rsp_valid, exp_grant); end
            checks++; if (rsp_data !== regs[exp_addr]) begin errors++; $display("FAIL rr_rsp_data%0d: got %h want %h", g, rsp_data, regs[exp_addr]); end
            tick;
        end
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
    endtask

    // rr_ptr = 1: requester 1 held in RESP for several cycles; other ready bits ignored.
    task automatic test_backpressure;
        req_valid = 4'b1111;
        rsp_ready = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick;
        tick;
        rsp_ready = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid%0d: got %b want 0010", i, rsp_valid); end
            checks++; if (rsp_data !== regs[5]) begin errors++; $display("FAIL bp_data%0d: got %h want %h", i, rsp_data, regs[5]); end
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready%0d: got %b want 0000", i, req_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy%0d: got %b want 1", i, busy); end
            if (i < 5) tick;
        end
        rsp_ready = 4'b0010;
        tick;
        rsp_ready = 4'b0000;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
        req_valid = 4'b0000;
    endtask

    // rr_ptr = 2: flush in IDLE, flush beating rsp_ready in RESP, flush in READ.
    task automatic test_flush;
        req_valid = 4'b0100;
        flush     = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL flush_idle_grant: got %b want 0000", req_ready); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL flush_after_grant: got %b want 0100", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        checks++; if (rsp_data !== regs[6]) begin errors++; $display("FAIL flush_resp_data: got %h want %h", rsp_data, regs[6]); end
        flush     = 1'b1;
        rsp_ready = 4'b0100;
        tick;
        flush     = 1'b0;
        rsp_ready = 4'b0000;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_resp_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL flush_resp_valid: got %b want 0000", rsp_valid); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL flush_rr_ptr3: got %b want 1000", req_ready); end
        tick;
        req_valid = 4'b0000;
        flush     = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_read_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL flush_read_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== regs[6]) begin errors++; $display("FAIL flush_read_hold: got %h want %h", rsp_data, regs[6]); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_rr_ptr0: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
    endtask

    // Complete requester 1 (rr_ptr -> 2), start requester 2, reset it in READ.
    task automatic test_reset_mid;
        req_valid = 4'b0010;
        tick;
        req_valid = 4'b0000;
        tick;
        rsp_ready = 4'b0010;
        tick;
        rsp_ready = 4'b0000;
        req_valid = 4'b0100;
        tick;
        req_valid = 4'b0000;
        #1;
        checks++; if (mux_sel !== 5'd6) begin errors++; $display("FAIL rmid_mux_sel: got %0d want 6", mux_sel); end
        rst = 1'b1;
        #1;
        checks++; if (mux_sel !== 5'd0) begin errors++; $display("FAIL rmid_mux_sel0: got %0d want 0", mux_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rmid_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rmid_rsp_data: got %h want 0", rsp_data); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rmid_req_ready: got %b want 0000", req_ready); end
        tick;
        rst       = 1'b0;
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rmid_rsp_valid_after: got %b want 0001", rsp_valid); end
        checks++; if (rsp_data !== regs[4]) begin errors++; $display("FAIL rmid_rsp_data_after: got %h want %h", rsp_data, regs[4]); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'hA500_0000 | k;
        regs[0]   = 32'hFFFFFFFF;
        regs[7]   = 32'hDEADBEEF;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_addr  = '0;
        rsp_ready = 4'b0000;
        flush     = 1'b0;

        test_reset;
        test_single;
        test_x0;
        test_round_robin;
        test_backpressure;
        test_flush;
        test_reset_mid;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
